// File: rtl/mdu_div_sequencer_if.sv
// rtl/mdu_div_sequencer_if.sv - request/response and divider-core signal bundle for mdu_div_sequencer
interface mdu_div_sequencer_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_ready_i;
    logic        div_start_o;
    logic [31:0] div_numerator_o;
    logic [31:0] div_denominator_o;
    logic [31:0] div_quotient_i;
    logic [31:0] div_remainder_i;
    logic        div_done_i;

    modport slave (
        input  req_valid_i,
        input  funct3_i,
        input  rs1_i,
        input  rs2_i,
        input  flush_i,
        input  resp_ready_i,
        input  div_quotient_i,
        input  div_remainder_i,
        input  div_done_i,
        output req_ready_o,
        output resp_valid_o,
        output resp_data_o,
        output div_start_o,
        output div_numerator_o,
        output div_denominator_o
    );

    modport master (
        output req_valid_i,
        output funct3_i,
        output rs1_i,
        output rs2_i,
        output flush_i,
        output resp_ready_i,
        output div_quotient_i,
        output div_remainder_i,
        output div_done_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  resp_data_o,
        input  div_start_o,
        input  div_numerator_o,
        input  div_denominator_o
    );
endinterface

// File: rtl/mdu_div_sequencer.sv
// rtl/mdu_div_sequencer.sv - sequences RISC-V DIV/DIVU/REM/REMU onto an unsigned divider core
module mdu_div_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    mdu_div_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        req_ready;
    logic        accept;
    logic        div_start;

    logic        req_signed;
    logic        req_rem;
    logic        rs1_neg;
    logic        rs2_neg;
    logic [31:0] rs1_mag;
    logic [31:0] rs2_mag;
    logic        div_zero;
    logic        sgn_ovf;
    logic        cache_hit;
    logic        bypass;
    logic [31:0] byp_quot;
    logic [31:0] byp_rem;

    logic        op_rem_q;
    logic        op_signed_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] num_q;
    logic [31:0] den_q;
    logic [31:0] resp_data_q;

    logic        cache_valid_q;
    logic        cache_signed_q;
    logic [31:0] cache_rs1_q;
    logic [31:0] cache_rs2_q;
    logic [31:0] cache_quot_q;
    logic [31:0] cache_rem_q;

    logic [31:0] fix_quot;
    logic [31:0] fix_rem;
    logic        capture;

    // funct3[2] is always 1 for the divide group, so only bits [1:0] select the op
    logic unused_funct3;
    assign unused_funct3 = bus.funct3_i[2];

    assign req_signed = ~bus.funct3_i[0];
    assign req_rem    = bus.funct3_i[1];
    assign rs1_neg    = req_signed & bus.rs1_i[31];
    assign rs2_neg    = req_signed & bus.rs2_i[31];
    assign rs1_mag    = rs1_neg ? (~bus.rs1_i + 32'd1) : bus.rs1_i;
    assign rs2_mag    = rs2_neg ? (~bus.rs2_i + 32'd1) : bus.rs2_i;

    assign div_zero  = (bus.rs2_i == 32'd0);
    assign sgn_ovf   = req_signed && (bus.rs1_i == 32'h8000_0000) && (bus.rs2_i == 32'hFFFF_FFFF);
    assign cache_hit = cache_valid_q && (bus.rs1_i == cache_rs1_q) &&
                       (bus.rs2_i == cache_rs2_q) && (req_signed == cache_signed_q);
    assign bypass    = div_zero | sgn_ovf | cache_hit;

    always_comb begin
        byp_quot = cache_quot_q;
        byp_rem  = cache_rem_q;
        if (div_zero) begin
            byp_quot = 32'hFFFF_FFFF;
            byp_rem  = bus.rs1_i;
        end else if (sgn_ovf) begin
            byp_quot = 32'h8000_0000;
            byp_rem  = 32'd0;
        end
    end

    // Core delivers magnitudes; restore RISC-V sign conventions on capture
    assign fix_quot = q_neg_q ? (~bus.div_quotient_i + 32'd1)  : bus.div_quotient_i;
    assign fix_rem  = r_neg_q ? (~bus.div_remainder_i + 32'd1) : bus.div_remainder_i;

    // Holding off accept until done keeps a core still busy from before reset untouched
    assign req_ready = (state_q == IDLE) && bus.div_done_i && !bus.flush_i;
    assign accept    = bus.req_valid_i && req_ready;
    assign capture   = (state_q == WAIT) && !bus.flush_i && bus.div_done_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bypass ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    div_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush_i) begin
                    state_d = DRAIN;
                end else if (bus.div_done_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.flush_i || bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (bus.div_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_rem_q       <= 1'b0;
            op_signed_q    <= 1'b0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            rs1_q          <= 32'd0;
            rs2_q          <= 32'd0;
            num_q          <= 32'd0;
            den_q          <= 32'd0;
            resp_data_q    <= 32'd0;
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_rs1_q    <= 32'd0;
            cache_rs2_q    <= 32'd0;
            cache_quot_q   <= 32'd0;
            cache_rem_q    <= 32'd0;
        end else begin
            if (accept) begin
                op_rem_q    <= req_rem;
                op_signed_q <= req_signed;
                q_neg_q     <= rs1_neg ^ rs2_neg;
                r_neg_q     <= rs1_neg;
                rs1_q       <= bus.rs1_i;
                rs2_q       <= bus.rs2_i;
                if (bypass) begin
                    resp_data_q <= req_rem ? byp_rem : byp_quot;
                end else begin
                    num_q <= rs1_mag;
                    den_q <= rs2_mag;
                end
            end
            if (capture) begin
                resp_data_q    <= op_rem_q ? fix_rem : fix_quot;
                cache_valid_q  <= 1'b1;
                cache_signed_q <= op_signed_q;
                cache_rs1_q    <= rs1_q;
                cache_rs2_q    <= rs2_q;
                cache_quot_q   <= fix_quot;
                cache_rem_q    <= fix_rem;
            end
            if (bus.flush_i) begin
                cache_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o       = req_ready;
    // A flush coinciding with resp_ready must not look like a completed handshake
    assign bus.resp_valid_o      = (state_q == RESP) && !bus.flush_i;
    assign bus.resp_data_o       = resp_data_q;
    assign bus.div_start_o       = div_start;
    assign bus.div_numerator_o   = num_q;
    assign bus.div_denominator_o = den_q;

endmodule

// File: tb/tb_mdu_div_sequencer.sv
// tb/tb_mdu_div_sequencer.sv - directed self-checking bench for mdu_div_sequencer
module tb_mdu_div_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_div_sequencer_if bus ();

    mdu_div_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Divider core model: done rises so that it is sampled 33 edges after the start edge
    logic        core_done = 1'b1;
    logic [5:0]  core_cnt  = 6'd0;
    logic [31:0] core_q    = 32'd0;
    logic [31:0] core_r    = 32'd0;

    always @(posedge clk) begin
        if (bus.div_start_o) begin
            core_cnt  <= 6'd32;
            core_done <= 1'b0;
            core_q    <= (bus.div_denominator_o == 32'd0) ? 32'hFFFF_FFFF
                         : bus.div_numerator_o / bus.div_denominator_o;
            core_r    <= (bus.div_denominator_o == 32'd0) ? bus.div_numerator_o
                         : bus.div_numerator_o % bus.div_denominator_o;
        end else if (core_cnt != 6'd0) begin
            core_cnt <= core_cnt - 6'd1;
            if (core_cnt == 6'd1) core_done <= 1'b1;
        end
    end

    assign bus.div_done_i      = core_done;
    assign bus.div_quotient_i  = core_q;
    assign bus.div_remainder_i = core_r;

    int start_cnt = 0;
    int resp_cnt  = 0;
    always @(posedge clk) begin
        if (bus.div_start_o)  start_cnt <= start_cnt + 1;
        if (bus.resp_valid_o) resp_cnt  <= resp_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic accept_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int guard;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = f3;
        bus.rs1_i       = a;
        bus.rs2_i       = b;
        guard = 0;
        while (!bus.req_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("accept_timeout", {31'd0, bus.req_ready_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    // lat counts edges from the accepting edge to the edge that samples resp_valid_o=1
    task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        accept_req(f3, a, b);
        lat = 1;
        while (!bus.resp_valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_resp();
        bus.resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
    endtask

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    initial begin
        int lat;
        int s0;
        int r0;
        int bad;
        int guard;

        rst              = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.funct3_i     = 3'd0;
        bus.rs1_i        = 32'd0;
        bus.rs2_i        = 32'd0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        check("rst_resp_data",  bus.resp_data_o, 32'd0);
        check("rst_start",      {31'd0, bus.div_start_o}, 32'd0);
        check("rst_num",        bus.div_numerator_o, 32'd0);
        check("rst_den",        bus.div_denominator_o, 32'd0);
        check("rst_req_ready",  {31'd0, bus.req_ready_o}, 32'd1);
        rst = 1'b0;

        // DIVU 100/7 through the core
        s0 = start_cnt;
        send_req(F_DIVU, 32'd100, 32'd7, lat);
        check("divu_lat",   lat, 35);
        check("divu_data",  bus.resp_data_o, 32'd14);
        check("divu_num",   bus.div_numerator_o, 32'd100);
        check("divu_den",   bus.div_denominator_o, 32'd7);
        take_resp();
        check("divu_starts", start_cnt - s0, 1);

        // DIV -7/2 then REM from cache
        send_req(F_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_neg_lat",  lat, 35);
        check("div_neg_data", bus.resp_data_o, 32'hFFFF_FFFD);
        take_resp();
        s0 = start_cnt;
        send_req(F_REM, 32'hFFFF_FFF9, 32'd2, lat);
        check("rem_hit_lat",  lat, 1);
        check("rem_hit_data", bus.resp_data_o, 32'hFFFF_FFFF);
        take_resp();
        check("rem_hit_starts", start_cnt - s0, 0);

        // Divide by zero
        s0 = start_cnt;
        send_req(F_DIVU, 32'h1234_5678, 32'd0, lat);
        check("dz_div_lat",  lat, 1);
        check("dz_div_data", bus.resp_data_o, 32'hFFFF_FFFF);
        take_resp();
        send_req(F_REMU, 32'h1234_5678, 32'd0, lat);
        check("dz_rem_lat",  lat, 1);
        check("dz_rem_data", bus.resp_data_o, 32'h1234_5678);
        take_resp();
        check("dz_starts", start_cnt - s0, 0);

        // Signed overflow
        s0 = start_cnt;
        send_req(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("ovf_div_lat",  lat, 1);
        check("ovf_div_data", bus.resp_data_o, 32'h8000_0000);
        take_resp();
        send_req(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("ovf_rem_lat",  lat, 1);
        check("ovf_rem_data", bus.resp_data_o, 32'd0);
        take_resp();
        check("ovf_starts", start_cnt - s0, 0);

        // Flush in WAIT cycle 10 -> DRAIN; following REMU must miss the cache
        s0 = start_cnt;
        r0 = resp_cnt;
        accept_req(F_DIVU, 32'd20, 32'd6);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("drain_ready", {31'd0, bus.req_ready_o}, 32'd0);
        bad = 0;
        guard = 0;
        while (!bus.div_done_i && guard < 100) begin
            if (bus.req_ready_o || bus.resp_valid_o) bad++;
            @(negedge clk);
            guard++;
        end
        check("drain_done_seen",    {31'd0, bus.div_done_i}, 32'd1);
        check("drain_no_ready",     bad, 0);
        check("drain_ready_at_done", {31'd0, bus.req_ready_o}, 32'd0);
        @(negedge clk);
        check("drain_exit_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("drain_no_resp",    resp_cnt - r0, 0);
        send_req(F_REMU, 32'd20, 32'd6, lat);
        check("post_flush_lat",  lat, 35);
        check("post_flush_data", bus.resp_data_o, 32'd2);
        take_resp();
        check("post_flush_starts", start_cnt - s0, 2);

        // resp_ready held low for 5 cycles
        send_req(F_DIV, 32'd100, 32'hFFFF_FFF9, lat);
        check("hold_lat", lat, 35);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_valid_%0d", i), {31'd0, bus.resp_valid_o}, 32'd1);
            check($sformatf("hold_data_%0d", i),  bus.resp_data_o, 32'hFFFF_FFF2);
        end
        take_resp();
        check("hold_released", {31'd0, bus.resp_valid_o}, 32'd0);

        // Reset pulse mid-WAIT
        accept_req(F_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        r0 = resp_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("mrst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        check("mrst_resp_data",  bus.resp_data_o, 32'd0);
        check("mrst_start",      {31'd0, bus.div_start_o}, 32'd0);
        check("mrst_num",        bus.div_numerator_o, 32'd0);
        check("mrst_den",        bus.div_denominator_o, 32'd0);
        check("mrst_req_ready",  {31'd0, bus.req_ready_o}, 32'd0);
        rst = 1'b0;
        bad = 0;
        guard = 0;
        while (!bus.div_done_i && guard < 100) begin
            if (bus.req_ready_o) bad++;
            @(negedge clk);
            guard++;
        end
        check("mrst_busy_no_ready", bad, 0);
        check("mrst_ready_done",    {31'd0, bus.req_ready_o}, 32'd1);
        check("mrst_no_resp",       resp_cnt - r0, 0);

        // Cache was cleared by reset: this REM must go through the core
        s0 = start_cnt;
        send_req(F_REM, 32'd100, 32'hFFFF_FFF9, lat);
        check("mrst_rem_lat",  lat, 35);
        check("mrst_rem_data", bus.resp_data_o, 32'd2);
        take_resp();
        check("mrst_rem_starts", start_cnt - s0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
